aes_shiftrows_stream: RTL
=========================

Name: aes_shiftrows_stream

Overview:
Serial-interface ShiftRows/InvShiftRows unit for the AES accelerator.
- Collects a 128-bit AES state from the 16-bit CPU-side datapath over several beats and applies forward or inverse ShiftRows, selected per block.
- Streams the result back out over the same narrow width, with valid/ready flow control on both sides.
- Sits between the CPU bus adapter and the SubBytes/MixColumns stages; replaces fixed-direction, purely combinational permutation logic.

Parameters:
DATA_W, 16, beat width in bits; legal values 8, 16, 32, 64, 128.
BEATS, 128/DATA_W, beats per block (derived localparam, not overridable).

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  synchronous active-high reset
data_i  in  DATA_W  input beat
valid_i  in  1  input beat valid
inv_i  in  1  1 = InvShiftRows, 0 = ShiftRows; sampled on the first beat of a block only
ready_o  out  1  unit accepts an input beat
data_o  out  DATA_W  output beat
valid_o  out  1  output beat valid
last_o  out  1  marks the final output beat of a block
ready_i  in  1  downstream accepts an output beat
busy_o  out  1  high in PERM or DRAIN, or when FILL holds a partial block

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
- State layout: word w_c = state[127-32c -: 32] for c = 0..3; row r byte = w_c[31-8r -: 8].
- Forward permutation: out col c row r = in col (c+r) mod 4 row r.
- Inverse permutation: out col c row r = in col (c-r) mod 4 row r.
- Beat order: the first beat carries state[127 -: DATA_W]; later beats carry successively lower slices, on both the input and output sides.
- FSM has three states: FILL, PERM, DRAIN. Reset state is FILL.
- FILL:
  - ready_o = 1; a handshake occurs when valid_i & ready_o.
  - Each handshake stores data_i into the slice selected by in_cnt (0..BEATS-1), then increments in_cnt.
  - On the handshake with in_cnt = 0, inv_i is latched into mode_q. inv_i at other beats is ignored.
  - On the handshake with in_cnt = BEATS-1, in_cnt wraps to 0 and the FSM goes to PERM.
- PERM:
  - Lasts exactly one cycle. ready_o = 0, valid_o = 0.
  - Permuted state (per mode_q) is registered into the output buffer; out_cnt is cleared.
  - Next state is DRAIN.
- DRAIN:
  - valid_o = 1; data_o = buffer slice out_cnt; last_o = (out_cnt == BEATS-1).
  - On valid_o & ready_i, out_cnt increments. The handshake on the last beat returns the FSM to FILL.
  - While ready_i = 0, data_o and last_o hold stable.
- Latency: the first output beat is valid 2 cycles after the cycle holding the last input handshake (one cycle in PERM).
- Throughput: one block per 2*BEATS+1 cycles when both sides never stall. No overlap: ready_o = 0 in PERM and DRAIN.
- DATA_W = 128: BEATS = 1; each block is FILL(1 handshake) -> PERM -> DRAIN(1 beat, last_o = 1).
- Reset values:
  - Registered outputs: valid_o = 0, last_o = 0, data_o = 0, busy_o = 0.
  - Internal: in_cnt = 0, out_cnt = 0, mode_q = 0, buffers = 0.
  - ready_o = 0 while reset_i = 1, and 1 in the first cycle after release.
- Reset mid-operation: a partial input block or undrained output is discarded with no output; the next block starts at beat 0.
- valid_i while ready_o = 0 is ignored; no data is captured.

Optional Feature:
Macro AES_SR_BYPASS_EN.
- Defined: adds port bypass_i (in, 1), latched with inv_i on the first beat of a block. When the latched value is 1, PERM copies the state unchanged, with the same latency and beat order. The inverse-mode latch is still updated but unused.
- Undefined: no bypass_i port; every block is permuted.

Test Plan:
1. DATA_W=16, inv_i=0, in beats 0x0001,0x0203,...,0x0e0f -> out beats 0x0005,0x0a0f,0x0409,0x0e03,0x080d,0x0207,0x0c01,0x060b; last_o only on the 8th beat; first valid_o 2 cycles after the last input handshake.
2. Same input, inv_i=1 -> out 0x000d,0x0a07,0x0401,0x0e0b,0x0805,0x020f,0x0c09,0x0603.
3. inv_i=1 on beat 0, toggled on beats 1-7 -> output identical to scenario 2.
4. ready_i low for 3 cycles at out beat 4 -> data_o holds 0x080d with valid_o=1; sequence completes unchanged; ready_o stays 0 until the last output handshake, then returns to 1.
5. reset_i pulsed after 5 input beats -> no valid_o; a following full block (scenario 1 data) produces exactly the scenario 1 output.
6. DATA_W=128, block 0x000102...0f, inv_i=0 -> single beat 0x00050a0f_04090e03_080d0207_0c01060b with last_o=1. With AES_SR_BYPASS_EN and bypass_i=1 -> output equals input.

Source files
------------

// File: rtl/aes_shiftrows_stream.sv
// Beat-serial AES ShiftRows / InvShiftRows unit: FILL collects a block, PERM permutes it, DRAIN streams it out.
// Optional macro AES_SR_BYPASS_EN adds bypass_i, which passes a block through unpermuted.
module aes_shiftrows_stream #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              inv_i,
`ifdef AES_SR_BYPASS_EN
  input  logic              bypass_i,
`endif
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int BEATS = 128 / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] PERM  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] in_cnt_r, in_cnt_nxt_s;
  logic [CNT_W-1:0] out_cnt_r, out_cnt_nxt_s;
  logic             mode_r;
  logic [127:0]     in_buf_r, out_buf_r, perm_s;
  logic             valid_r, valid_nxt_s;
  logic             last_r, last_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             in_hs_s, out_hs_s;

  // Column c of the output takes row r from column (c+r) mod 4, or (c-r) mod 4 when inverse.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
        o[127-32*c-8*r -: 8] = s[127-32*src-8*r -: 8];
      end
    end
    return o;
  endfunction

`ifdef AES_SR_BYPASS_EN
  logic bypass_r;
  assign perm_s = bypass_r ? in_buf_r : shift_rows(in_buf_r, mode_r);
`else
  assign perm_s = shift_rows(in_buf_r, mode_r);
`endif

  assign in_hs_s  = valid_i & (state_r == FILL);
  assign out_hs_s = valid_r & ready_i & (state_r == DRAIN);

  assign ready_o = (state_r == FILL) & ~reset_i;
  assign data_o  = out_buf_r[127 -: DATA_W];
  assign valid_o = valid_r;
  assign last_o  = last_r;
  assign busy_o  = busy_r;

  // Next-state, beat counters and next values of the registered output flags.
  always_comb begin
    state_nxt_s   = state_r;
    in_cnt_nxt_s  = in_cnt_r;
    out_cnt_nxt_s = out_cnt_r;
    valid_nxt_s   = valid_r;
    last_nxt_s    = last_r;
    case (state_r)
      FILL: begin
        if (in_hs_s) begin
          if (in_cnt_r == LAST_CNT) begin
            in_cnt_nxt_s = '0;
            state_nxt_s  = PERM;
          end else begin
            in_cnt_nxt_s = in_cnt_r + CNT_W'(1);
          end
        end else begin
          in_cnt_nxt_s = in_cnt_r;
        end
      end
      PERM: begin
        state_nxt_s   = DRAIN;
        out_cnt_nxt_s = '0;
        valid_nxt_s   = 1'b1;
        last_nxt_s    = (LAST_CNT == '0);
      end
      DRAIN: begin
        if (out_hs_s) begin
          if (out_cnt_r == LAST_CNT) begin
            state_nxt_s   = FILL;
            out_cnt_nxt_s = '0;
            valid_nxt_s   = 1'b0;
            last_nxt_s    = 1'b0;
          end else begin
            out_cnt_nxt_s = out_cnt_r + CNT_W'(1);
            last_nxt_s    = ((out_cnt_r + CNT_W'(1)) == LAST_CNT);
          end
        end else begin
          out_cnt_nxt_s = out_cnt_r;
        end
      end
      default: begin
        state_nxt_s   = FILL;
        in_cnt_nxt_s  = '0;
        out_cnt_nxt_s = '0;
        valid_nxt_s   = 1'b0;
        last_nxt_s    = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != FILL) | (in_cnt_nxt_s != '0);
  end

  // State, buffers and registered outputs; input shifts in at the bottom, output drains from the top.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= FILL;
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
      mode_r    <= 1'b0;
      in_buf_r  <= 128'd0;
      out_buf_r <= 128'd0;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef AES_SR_BYPASS_EN
      bypass_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      in_cnt_r  <= in_cnt_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
      valid_r   <= valid_nxt_s;
      last_r    <= last_nxt_s;
      busy_r    <= busy_nxt_s;
      if (in_hs_s) begin
        in_buf_r <= (in_buf_r << DATA_W) | 128'(data_i);
      end
      if (in_hs_s && (in_cnt_r == '0)) begin
        mode_r   <= inv_i;
`ifdef AES_SR_BYPASS_EN
        bypass_r <= bypass_i;
`endif
      end
      if (state_r == PERM) begin
        out_buf_r <= perm_s;
      end else if (out_hs_s) begin
        out_buf_r <= out_buf_r << DATA_W;
      end
    end
  end

endmodule
